// File: rtl/ps2_pkg.sv
// ps2_pkg: shared definitions for the PS/2 receive sequencer.
//   ps2_state_t            - frame walker states
//   FRAME_*_POS            - bit positions within an 11-bit (8 data bit) frame
//   DEFAULT_TIMEOUT_CYCLES - watchdog default, 100 us at 50 MHz
//   bit_cnt_width()        - width of the data bit counter for a given data width
package ps2_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DATA   = 2'd1,
        PARITY = 2'd2,
        STOP   = 2'd3
    } ps2_state_t;

    localparam int unsigned FRAME_START_POS        = 0;
    localparam int unsigned FRAME_PARITY_POS       = 9;
    localparam int unsigned FRAME_STOP_POS         = 10;
    localparam int unsigned DEFAULT_TIMEOUT_CYCLES = 5000;

    function automatic int unsigned bit_cnt_width(input int unsigned data_width);
        return $clog2(data_width + 1);
    endfunction

endpackage

// File: rtl/ps2_pin_sync.sv
// ps2_pin_sync: multi-flop synchronizers for the raw PS/2 clock and data pins
// plus PS/2 clock falling-edge detection.
//   clk, reset       - system clock, asynchronous active-low reset
//   ps2_clk/ps2_data - raw asynchronous pins
//   data_s           - synchronized data line
//   fall_det         - high for one cycle when the synchronized clock goes 1 -> 0
module ps2_pin_sync #(
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic reset,
    input  logic ps2_clk,
    input  logic ps2_data,
    output logic data_s,
    output logic fall_det
);

    logic [SYNC_STAGES-1:0] clk_sync;
    logic [SYNC_STAGES-1:0] data_sync;
    logic                   clk_prev;

    // Flops reset to the idle-high bus level so reset release never
    // looks like a falling edge.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            clk_sync  <= '1;
            data_sync <= '1;
            clk_prev  <= 1'b1;
        end else begin
            clk_sync  <= {clk_sync[SYNC_STAGES-2:0], ps2_clk};
            data_sync <= {data_sync[SYNC_STAGES-2:0], ps2_data};
            clk_prev  <= clk_sync[SYNC_STAGES-1];
        end
    end

    assign data_s   = data_sync[SYNC_STAGES-1];
    assign fall_det = clk_prev & ~clk_sync[SYNC_STAGES-1];

endmodule

// File: rtl/ps2_frame_sequencer.sv
// ps2_frame_sequencer: walks PS/2 receive frames (start, data LSB-first,
// odd parity, stop) and drives the external shift/holding registers.
//   clk, reset        - system clock, asynchronous active-low reset
//   rx_en             - receive enable; low aborts and holds IDLE
//   ps2_clk, ps2_data - raw PS/2 pins
//   shift_en, bit_out - shift register strobe and the bit to shift in
//   write_en          - holding register capture strobe
//   frame_valid       - holding register has an unconsumed byte
//   frame_ready       - consumer accepts when high with frame_valid
//   busy              - frame in progress
//   parity_err, framing_err, timeout_err, overrun - one-cycle error pulses
module ps2_frame_sequencer
    import ps2_pkg::*;
#(
    parameter int unsigned DATA_WIDTH     = 8,
    parameter int unsigned SYNC_STAGES    = 2,
    parameter int unsigned TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES
) (
    input  logic clk,
    input  logic reset,
    input  logic rx_en,
    input  logic ps2_clk,
    input  logic ps2_data,
    output logic shift_en,
    output logic bit_out,
    output logic write_en,
    output logic frame_valid,
    input  logic frame_ready,
    output logic busy,
    output logic parity_err,
    output logic framing_err,
    output logic timeout_err,
    output logic overrun
);

    localparam int unsigned CNT_W = bit_cnt_width(DATA_WIDTH);
    localparam int unsigned WD_W  = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_WIDTH - 1);
    // Counter is cleared in the fall_det cycle, so it holds TIMEOUT_CYCLES-2
    // in the cycle where its next value would reach TIMEOUT_CYCLES-1.
    localparam logic [WD_W-1:0]  WD_LAST  = WD_W'(TIMEOUT_CYCLES - 2);

    ps2_state_t       state;
    logic [CNT_W-1:0] bit_cnt;
    logic [WD_W-1:0]  wdog;
    logic             par_acc;
    logic             par_ok;
    logic             good_q;
    logic             data_s;
    logic             fall_det;
    logic             wd_expire;

    ps2_pin_sync #(
        .SYNC_STAGES(SYNC_STAGES)
    ) u_pin_sync (
        .clk      (clk),
        .reset    (reset),
        .ps2_clk  (ps2_clk),
        .ps2_data (ps2_data),
        .data_s   (data_s),
        .fall_det (fall_det)
    );

    assign busy      = (state != IDLE);
    assign wd_expire = busy && !fall_det && (wdog == WD_LAST);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state       <= IDLE;
            bit_cnt     <= '0;
            wdog        <= '0;
            par_acc     <= 1'b0;
            par_ok      <= 1'b0;
            good_q      <= 1'b0;
            shift_en    <= 1'b0;
            bit_out     <= 1'b0;
            parity_err  <= 1'b0;
            framing_err <= 1'b0;
            timeout_err <= 1'b0;
        end else begin
            shift_en    <= 1'b0;
            good_q      <= 1'b0;
            parity_err  <= 1'b0;
            framing_err <= 1'b0;
            timeout_err <= 1'b0;

            if (!rx_en) begin
                state   <= IDLE;
                bit_cnt <= '0;
                wdog    <= '0;
            end else if (wd_expire) begin
                timeout_err <= 1'b1;
                state       <= IDLE;
                wdog        <= '0;
            end else begin
                if (busy && !fall_det)
                    wdog <= wdog + 1'b1;
                else
                    wdog <= '0;

                if (fall_det) begin
                    case (state)
                        IDLE: begin
                            if (!data_s) begin
                                state   <= DATA;
                                bit_cnt <= '0;
                                par_acc <= 1'b0;
                            end else begin
                                framing_err <= 1'b1;
                            end
                        end
                        DATA: begin
                            shift_en <= 1'b1;
                            bit_out  <= data_s;
                            par_acc  <= par_acc ^ data_s;
                            bit_cnt  <= bit_cnt + 1'b1;
                            if (bit_cnt == LAST_BIT)
                                state <= PARITY;
                        end
                        PARITY: begin
                            par_ok <= par_acc ^ data_s;
                            state  <= STOP;
                        end
                        STOP: begin
                            if (!data_s)
                                framing_err <= 1'b1;
                            else if (!par_ok)
                                parity_err <= 1'b1;
                            else
                                good_q <= 1'b1;
                            state <= IDLE;
                        end
                        default: state <= IDLE;
                    endcase
                end
            end
        end
    end

    // The capture decision must see frame_ready in the strobe cycle itself,
    // so write_en/overrun are resolved from the registered good-frame flag.
    assign write_en = good_q & (~frame_valid | frame_ready);
    assign overrun  = good_q & frame_valid & ~frame_ready;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            frame_valid <= 1'b0;
        else if (write_en)
            frame_valid <= 1'b1;
        else if (frame_valid && frame_ready)
            frame_valid <= 1'b0;
    end

endmodule
